collatz_range_par: RTL

- Parametrised successor to the single-iterator Collatz range block: sweeps RAM_WORDS consecutive start values using LANES parallel Collatz engines.
- Stores each iteration count in an on-chip result RAM with an independent read port.
- Also reports the maximum count and its index, plus an overflow flag.
- Sits behind the lab's bus-facing register wrapper, which drives go/start and reads results back.

---
 rtl/collatz_pkg.sv | 22 ++
 rtl/collatz_lane.sv | 73 +++++++
 rtl/collatz_range_par.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared types and constants for the parallel Collatz range sweeper.
// Lane results travel as one packed struct so the arbiter can mux them whole.
package collatz_pkg;

  localparam int unsigned RES_CNT_BITS = 16;
  localparam int unsigned RES_IDX_BITS = 4;

  localparam logic [RES_CNT_BITS-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [RES_IDX_BITS-1:0] idx;
    logic [RES_CNT_BITS-1:0] count;
    logic                    valid;
  } lane_res_t;

endpackage

// File: rtl/collatz_lane.sv
// One Collatz engine: loads (n, idx), takes one step per cycle, then holds
// its result until the arbiter acknowledges it.
module collatz_lane
  import collatz_pkg::*;
#(
  parameter int unsigned N_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic [N_BITS-1:0]       i_n,
  input  logic [RES_IDX_BITS-1:0] i_idx,
  input  logic                    i_ack,
  output logic                    o_idle,
  output lane_res_t               o_result
);

  localparam int unsigned W = N_BITS + 2;

  logic                    r_busy;
  logic                    r_valid;
  logic [W-1:0]            r_n;
  logic [RES_CNT_BITS-1:0] r_cnt;
  logic [RES_IDX_BITS-1:0] r_idx;

  logic [W-1:0] w_triple;
  logic         w_too_big;
  logic         w_cnt_sat;

  // Two guard bits catch 3n+1 leaving the N_BITS range.
  assign w_triple  = r_n + (r_n << 1) + W'(1);
  assign w_too_big = |w_triple[W-1:N_BITS];
  assign w_cnt_sat = (r_cnt == CNT_SAT);

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_idx <= i_idx;
      r_n   <= W'(i_n);
      if (i_n == '0) begin
        r_cnt   <= '0;
        r_valid <= 1'b1;
      end else begin
        r_cnt  <= RES_CNT_BITS'(1);
        r_busy <= 1'b1;
      end
    end else if (r_busy) begin
      if (w_cnt_sat || r_n == W'(1)) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end else if (r_n[0] && w_too_big) begin
        r_cnt   <= CNT_SAT;
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end else begin
        r_n   <= r_n[0] ? w_triple : (r_n >> 1);
        r_cnt <= r_cnt + RES_CNT_BITS'(1);
      end
    end else if (r_valid && i_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign o_idle   = !r_busy && !r_valid;
  assign o_result = '{idx: r_idx, count: r_cnt, valid: r_valid};

endmodule

// File: rtl/collatz_range_par.sv
// Sweeps RAM_WORDS consecutive start values over LANES Collatz engines,
// storing each count in a result RAM and tracking the maximum and overflow.
module collatz_range_par
  import collatz_pkg::*;
#(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned CNT_BITS  = 16,
  parameter int unsigned RAM_WORDS = 16,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned LANES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [N_BITS-1:0]    start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [CNT_BITS-1:0]  rdata,
  output logic [CNT_BITS-1:0]  max_count,
  output logic [ADDR_BITS-1:0] max_index
);

  localparam logic [ADDR_BITS:0] K_END  = (ADDR_BITS + 1)'(RAM_WORDS);
  localparam logic [ADDR_BITS:0] K_LAST = (ADDR_BITS + 1)'(RAM_WORDS - 1);

  if (CNT_BITS != RES_CNT_BITS || ADDR_BITS != RES_IDX_BITS ||
      LANES < 1 || LANES > RAM_WORDS) begin : g_param_check
    $error("collatz_range_par: CNT_BITS/ADDR_BITS must match collatz_pkg and LANES must be 1..RAM_WORDS");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [N_BITS-1:0]    r_start;
  logic [ADDR_BITS:0]   r_next_k;
  logic [ADDR_BITS:0]   r_wr_cnt;
  logic                 r_overflow;
  logic                 r_max_vld;
  logic [CNT_BITS-1:0]  r_max_count;
  logic [ADDR_BITS-1:0] r_max_index;
  logic [CNT_BITS-1:0]  r_rdata;
  logic [CNT_BITS-1:0]  r_mem [RAM_WORDS];

  logic [LANES-1:0] w_idle;
  logic [LANES-1:0] w_load;
  logic [LANES-1:0] w_ack;
  lane_res_t        w_res [LANES];
  lane_res_t        w_wr;
  logic             w_found_idle;
  logic             w_found_res;
  logic             w_accept;
  logic             w_dispatch;
  logic             w_we;
  logic             w_last_wr;
  logic             w_new_max;
  logic [N_BITS-1:0] w_lane_n;

  assign w_accept   = go && (r_state != RUN);
  assign w_dispatch = (r_state == RUN) && (r_next_k != K_END);
  assign w_lane_n   = r_start + N_BITS'(r_next_k);

  // Lowest idle lane takes the next index; lowest finished lane owns the write port.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_load       = '0;
    w_ack        = '0;
    w_wr         = '0;
    w_found_idle = 1'b0;
    w_found_res  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (w_dispatch && !w_found_idle && w_idle[i]) begin
        w_load[i]    = 1'b1;
        w_found_idle = 1'b1;
      end
      if ((r_state == RUN) && !w_found_res && w_res[i].valid) begin
        w_ack[i]    = 1'b1;
        w_wr        = w_res[i];
        w_found_res = 1'b1;
      end
    end
  end

  assign w_we      = w_found_res && !reset;
  assign w_last_wr = w_we && (r_wr_cnt == K_LAST);
  assign w_new_max = !r_max_vld || (w_wr.count > r_max_count) ||
                     ((w_wr.count == r_max_count) && (w_wr.idx < r_max_index));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    collatz_lane #(.N_BITS(N_BITS)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load[g]),
      .i_n      (w_lane_n),
      .i_idx    (r_next_k[ADDR_BITS-1:0]),
      .i_ack    (w_ack[g]),
      .o_idle   (w_idle[g]),
      .o_result (w_res[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (go) w_state_next = RUN;
      RUN:        if (w_last_wr) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start     <= '0;
      r_next_k    <= '0;
      r_wr_cnt    <= '0;
      r_overflow  <= 1'b0;
      r_max_vld   <= 1'b0;
      r_max_count <= '0;
      r_max_index <= '0;
    end else if (w_accept) begin
      r_start     <= start;
      r_next_k    <= '0;
      r_wr_cnt    <= '0;
      r_overflow  <= 1'b0;
      r_max_vld   <= 1'b0;
      r_max_count <= '0;
      r_max_index <= '0;
    end else begin
      if (|w_load) r_next_k <= r_next_k + (ADDR_BITS + 1)'(1);
      if (w_we) begin
        r_wr_cnt <= r_wr_cnt + (ADDR_BITS + 1)'(1);
        if (w_wr.count == CNT_SAT) r_overflow <= 1'b1;
        if (w_new_max) begin
          r_max_vld   <= 1'b1;
          r_max_count <= w_wr.count;
          r_max_index <= w_wr.idx;
        end
      end
    end
  end

  // NOTE: the result RAM is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr.idx] <= w_wr.count;
  end

  always_ff @(posedge clk) begin
    if (reset) r_rdata <= '0;
    else       r_rdata <= r_mem[raddr];
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign overflow  = r_overflow;
  assign rdata     = r_rdata;
  assign max_count = r_max_count;
  assign max_index = r_max_index;

endmodule
